// File: rtl/edge_check_pkg.sv
// Shared constants for the multi-channel edge checker.
// Provides the 2-bit edge mode encodings, default parameter values and the
// direction-qualification helper used by every channel.
package edge_check_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int unsigned DEF_CH          = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_LEN    = 4;
  localparam int unsigned DEF_CNT_W       = 16;

  // Mode bit 0 enables rising edges, bit 1 enables falling edges.
  function automatic logic edge_qualifies(input logic [1:0] mode,
                                          input logic       rise,
                                          input logic       fall);
    return (rise && mode[0]) || (fall && mode[1]);
  endfunction

endpackage

// File: rtl/edge_check_multi_chan.sv
// One edge-checker channel: synchroniser, glitch filter, edge detect,
// saturating edge counter and sticky flag.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   sig_i          asynchronous input
//   mode_i         2-bit edge mode (off/rise/fall/both)
//   armed_i        block-level arm status; filter tracks input while low
//   clr_i          synchronous clear of counter and flag
//   pulse_o        one-cycle pulse per qualified edge
//   level_o        filtered, synchronised level
//   cnt_o          saturating qualified-edge count
//   flag_o         sticky edge-seen flag
module edge_chan
  import edge_check_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic [1:0]       mode_i,
  input  logic             armed_i,
  input  logic             clr_i,
  output logic             pulse_o,
  output logic             level_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             flag_o
);

  localparam int unsigned      FW        = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_c;
  logic [FW-1:0]          filt_q, filt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   toggle_c, rise_c, fall_c, qual_c;

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Filter, edge qualification, counter and flag next-state.
  always_comb begin
    filt_d   = filt_q;
    level_d  = level_q;
    toggle_c = 1'b0;
    if (!armed_i) begin
      // Follow the synchroniser directly so no edge is seen at startup.
      level_d = sync_c;
      filt_d  = '0;
    end else if (sync_c == level_q) begin
      filt_d = '0;
    end else if (filt_q == FILT_LAST) begin
      toggle_c = 1'b1;
      level_d  = ~level_q;
      filt_d   = '0;
    end else begin
      filt_d = filt_q + FW'(1);
    end

    rise_c  = toggle_c & ~level_q;
    fall_c  = toggle_c & level_q;
    qual_c  = edge_qualifies(mode_i, rise_c, fall_c);
    pulse_d = qual_c;

    cnt_d  = cnt_q;
    flag_d = flag_q;
    // Clear wins over a coincident edge; that edge is dropped from the count.
    if (clr_i) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (qual_c) begin
      flag_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      filt_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      filt_q  <= filt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;
  assign cnt_o   = cnt_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/edge_check_multi.sv
// Multi-channel edge checker top: shared arm counter plus CH channels.
// Ports:
//   sys_clk, sys_rst  clock, asynchronous active-high reset
//   signal_in         CH asynchronous trigger inputs
//   edge_mode         2 bits per channel, channel i at [2i+1:2i]
//   clr_cnt           per-channel synchronous counter/flag clear
//   signal_out        one-cycle pulse per qualified edge
//   level_out         filtered, synchronised levels
//   edge_cnt          CNT_W-bit saturating counts, channel i at [i*CNT_W +: CNT_W]
//   edge_flag         sticky edge-seen flags
module edge_check_multi
  import edge_check_pkg::*;
#(
  parameter int unsigned CH          = DEF_CH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [CH-1:0]       signal_in,
  input  logic [2*CH-1:0]     edge_mode,
  input  logic [CH-1:0]       clr_cnt,
  output logic [CH-1:0]       signal_out,
  output logic [CH-1:0]       level_out,
  output logic [CH*CNT_W-1:0] edge_cnt,
  output logic [CH-1:0]       edge_flag
);

  localparam int unsigned   ARM_LEN  = SYNC_STAGES + FILT_LEN;
  localparam int unsigned   AW       = $clog2(ARM_LEN + 1);
  localparam logic [AW-1:0] ARM_DONE = AW'(ARM_LEN);

  logic [AW-1:0] arm_q, arm_d;
  logic          armed_c;

  assign armed_c = (arm_q == ARM_DONE);

  // Arm counter runs once after reset release, then holds.
  always_comb begin
    arm_d = arm_q;
    if (!armed_c) arm_d = arm_q + AW'(1);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) arm_q <= '0;
    else         arm_q <= arm_d;
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .sig_i   (signal_in[i]),
      .mode_i  (edge_mode[2*i +: 2]),
      .armed_i (armed_c),
      .clr_i   (clr_cnt[i]),
      .pulse_o (signal_out[i]),
      .level_o (level_out[i]),
      .cnt_o   (edge_cnt[i*CNT_W +: CNT_W]),
      .flag_o  (edge_flag[i])
    );
  end

endmodule

// File: tb/tb_edge_check_multi.sv
// Self-checking bench for edge_check_multi: directed scenarios plus random
// toggling, compared every cycle against a sample-window reference model.
`timescale 1ns/1ps
module tb_edge_check_multi;
  import edge_check_pkg::*;

  localparam int unsigned CH    = 4;
  localparam int unsigned S     = 2;
  localparam int unsigned F     = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned LAT   = S + F;
  localparam int unsigned DEPTH = S + F;
  localparam int          HALF  = 40;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b1;
  logic [CH-1:0]       signal_in;
  logic [2*CH-1:0]     edge_mode;
  logic [CH-1:0]       clr_cnt;
  logic [CH-1:0]       signal_out;
  logic [CH-1:0]       level_out;
  logic [CH*W-1:0]     edge_cnt;
  logic [CH-1:0]       edge_flag;

  // Narrow-counter instance for saturation and clear-priority checks.
  logic       s_in, s_clr, s_out, s_lvl, s_flag;
  logic [1:0] s_mode;
  logic [1:0] s_cnt;

  edge_check_multi #(.CH(CH), .SYNC_STAGES(S), .FILT_LEN(F), .CNT_W(W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .signal_in  (signal_in),
    .edge_mode  (edge_mode),
    .clr_cnt    (clr_cnt),
    .signal_out (signal_out),
    .level_out  (level_out),
    .edge_cnt   (edge_cnt),
    .edge_flag  (edge_flag)
  );

  edge_check_multi #(.CH(1), .SYNC_STAGES(S), .FILT_LEN(F), .CNT_W(2)) dut_sat (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .signal_in  (s_in),
    .edge_mode  (s_mode),
    .clr_cnt    (s_clr),
    .signal_out (s_out),
    .level_out  (s_lvl),
    .edge_cnt   (s_cnt),
    .edge_flag  (s_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level change is accepted once the last F synchronised
  // samples all disagree with the current level; synchronised sample at an
  // edge is the input sampled S edges earlier.
  logic          samp [CH][DEPTH];
  logic [CH-1:0] m_level, m_pulse, m_flag;
  int unsigned   m_cnt [CH];
  int unsigned   m_since;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int j = 0; j < DEPTH; j++) samp[c][j] = 1'b0;
      m_cnt[c] = 0;
    end
    m_level = '0;
    m_pulse = '0;
    m_flag  = '0;
    m_since = 0;
  endtask

  task automatic model_step();
    bit         armed, all_diff, qual;
    logic [1:0] mode;
    if (m_since < 1000) m_since++;
    armed = (m_since > LAT);
    for (int c = 0; c < CH; c++) begin
      for (int j = DEPTH - 1; j > 0; j--) samp[c][j] = samp[c][j-1];
      samp[c][0] = signal_in[c];
      mode = edge_mode[2*c +: 2];
      qual = 1'b0;
      if (!armed) begin
        m_level[c] = samp[c][S];
      end else begin
        all_diff = 1'b1;
        for (int j = 0; j < F; j++)
          if (samp[c][S+j] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          if (!m_level[c]) qual = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
          else             qual = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
          m_level[c] = ~m_level[c];
        end
      end
      m_pulse[c] = qual;
      if (clr_cnt[c]) begin
        m_cnt[c]  = 0;
        m_flag[c] = 1'b0;
      end else if (qual) begin
        m_flag[c] = 1'b1;
        if (m_cnt[c] < (1 << W) - 1) m_cnt[c]++;
      end
    end
  endtask

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) model_reset();
    else         model_step();
  end

  logic chk_en = 1'b0;

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("level", 64'(level_out), 64'(m_level));
      check("pulse", 64'(signal_out), 64'(m_pulse));
      check("flag",  64'(edge_flag), 64'(m_flag));
      for (int c = 0; c < CH; c++)
        check($sformatf("cnt%0d", c), 64'(edge_cnt[c*W +: W]), 64'(m_cnt[c]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // 11 toggles of a square wave on ch0, starting low.
  task automatic run_square(input logic [1:0] mode, input int exp_n, input bit exp_flag,
                            input string tag);
    int pulses;
    int lat;
    edge_mode[1:0] = EDGE_OFF;
    signal_in[0]   = 1'b0;
    tick(12);
    clr_cnt[0] = 1'b1;
    tick(1);
    clr_cnt[0]     = 1'b0;
    edge_mode[1:0] = mode;
    pulses = 0;
    for (int t = 0; t < 11; t++) begin
      signal_in[0] = ~signal_in[0];
      lat = 0;
      for (int k = 1; k <= HALF; k++) begin
        tick(1);
        if (signal_out[0]) begin
          pulses++;
          if (lat == 0) lat = k;
        end
      end
      if (mode == EDGE_BOTH) check({tag, "_latency"}, 64'(lat), 64'(LAT));
    end
    check({tag, "_pulses"}, 64'(pulses), 64'(exp_n));
    check({tag, "_cnt"},    64'(edge_cnt[W-1:0]), 64'(exp_n));
    check({tag, "_flag"},   64'(edge_flag[0]), 64'(exp_flag));
    check({tag, "_level"},  64'(level_out[0]), 64'(1));
  endtask

  initial begin
    int p1, p2, np;
    signal_in = 4'b0100;
    edge_mode = {CH{EDGE_BOTH}};
    clr_cnt   = '0;
    s_in      = 1'b0;
    s_mode    = EDGE_BOTH;
    s_clr     = 1'b0;

    tick(10);
    check("rst_level", 64'(level_out), 64'(0));
    check("rst_pulse", 64'(signal_out), 64'(0));
    check("rst_cnt",   64'(edge_cnt), 64'(0));
    check("rst_flag",  64'(edge_flag), 64'(0));
    chk_en  = 1'b1;
    sys_rst = 1'b0;

    // ch2 high through reset release: level follows, no edge reported.
    tick(6);
    check("hi_at_rst_level", 64'(level_out[2]), 64'(1));
    check("hi_at_rst_cnt",   64'(edge_cnt[2*W +: W]), 64'(0));
    check("hi_at_rst_flag",  64'(edge_flag[2]), 64'(0));
    tick(10);

    run_square(EDGE_BOTH, 11, 1'b1, "sq_both");
    run_square(EDGE_RISE, 6,  1'b1, "sq_rise");
    run_square(EDGE_FALL, 5,  1'b1, "sq_fall");
    run_square(EDGE_OFF,  0,  1'b0, "sq_off");

    // Glitches on ch1: 3 cycles rejected, 4 cycles accepted.
    signal_in[1] = 1'b1;
    tick(3);
    signal_in[1] = 1'b0;
    tick(12);
    check("glitch3_level", 64'(level_out[1]), 64'(0));
    check("glitch3_cnt",   64'(edge_cnt[W +: W]), 64'(0));
    signal_in[1] = 1'b1;
    p1 = 0; p2 = 0; np = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) signal_in[1] = 1'b0;
      tick(1);
      if (signal_out[1]) begin
        np++;
        if (np == 1) p1 = k;
        else         p2 = k;
      end
    end
    check("glitch4_pulses", 64'(np), 64'(2));
    check("glitch4_rise_at", 64'(p1), 64'(LAT));
    check("glitch4_spacing", 64'(p2 - p1), 64'(F));
    check("glitch4_cnt", 64'(edge_cnt[W +: W]), 64'(2));

    // Random toggling, mode changes and clears; the model checks every cycle.
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) signal_in[c] = ~signal_in[c];
        clr_cnt[c] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 49) == 0) edge_mode[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      tick(1);
    end
    clr_cnt = '0;
    tick(10);

    // Narrow counter saturates at 3.
    for (int t = 0; t < 5; t++) begin
      s_in = ~s_in;
      tick(10);
    end
    check("sat_cnt",  64'(s_cnt), 64'(3));
    check("sat_flag", 64'(s_flag), 64'(1));
    // Clear on the same edge as a qualified edge.
    s_in = ~s_in;
    tick(5);
    s_clr = 1'b1;
    tick(1);
    s_clr = 1'b0;
    check("clr_edge_pulse", 64'(s_out), 64'(1));
    check("clr_edge_cnt",   64'(s_cnt), 64'(0));
    check("clr_edge_flag",  64'(s_flag), 64'(0));
    tick(1);
    check("clr_edge_after_cnt", 64'(s_cnt), 64'(0));

    // Reset in the middle of a pulse.
    edge_mode[1:0] = EDGE_BOTH;
    signal_in[0]   = 1'b0;
    tick(12);
    signal_in[0] = 1'b1;
    tick(LAT);
    check("pre_rst_pulse", 64'(signal_out[0]), 64'(1));
    #1 sys_rst = 1'b1;
    #1;
    check("mid_rst_pulse", 64'(signal_out), 64'(0));
    check("mid_rst_level", 64'(level_out), 64'(0));
    check("mid_rst_cnt",   64'(edge_cnt), 64'(0));
    check("mid_rst_flag",  64'(edge_flag), 64'(0));
    check("mid_rst_sat",   64'({s_out, s_lvl, s_cnt, s_flag}), 64'(0));
    tick(3);
    sys_rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick(1);
      check("arm_no_pulse", 64'(signal_out[0]), 64'(0));
    end
    check("arm_level", 64'(level_out[0]), 64'(1));
    check("arm_cnt",   64'(edge_cnt[W-1:0]), 64'(0));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
